uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller. It integrates the bit/edge counters, the 3-sample majority sampler, the deserializer, parity checking and stop-bit checking around one frame FSM. It sits between the pre-synchronized RX pin and the system register/FIFO path. Compared with the fixed 8-bit receiver it adds:
- configurable data width;
- runtime oversampling prescale;
- even/odd parity selection;
- 1 or 2 stop bits;
- per-frame error reporting;
- break recovery.

---
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of the UART receiver's serial input, frame configuration and
// frame-result outputs between the line front end and the register/FIFO side.
interface uart_rx_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic [PRESC_W-1:0] PRESCALE;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic               STP2_EN;
  logic [DATA_W-1:0]  P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;
  logic               strt_glitch;
  logic               busy;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, STP2_EN,
    input  P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, STP2_EN,
    output P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: majority-vote sampling, configurable
// data width, optional even/odd parity, 1 or 2 stop bits, break recovery.
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  edge_q, edge_d, presc_q, half;
  logic [3:0]          bit_q, bit_d, data_last, stop_last;
  logic                par_en_q, par_typ_q, stp2_q;
  logic                s0_q, s1_q, rx, maj, wrap, decide, cfg_load;
  logic [DATA_W-1:0]   shift_q, shift_d, pdata_q, pdata_d;
  logic                par_flag_q, par_flag_d;
  logic                dv_q, dv_d, perr_q, perr_d, serr_q, serr_d, glitch_q, glitch_d;

  assign rx        = bus.RX_IN;
  assign half      = presc_q >> 1;
  assign wrap      = (edge_q == presc_q - ONE);
  assign decide    = (edge_q == half + ONE);
  assign maj       = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
  assign data_last = 4'(DATA_W);
  // Bit index of the final stop bit; bit 0 is the start bit.
  assign stop_last = 4'(DATA_W + 1) + {3'b000, par_en_q} + {3'b000, stp2_q};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stp2_q     <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      pdata_q    <= '0;
      par_flag_q <= 1'b0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      par_flag_q <= par_flag_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      glitch_q   <= glitch_d;
      if (cfg_load) begin
        presc_q   <= bus.PRESCALE;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        stp2_q    <= bus.STP2_EN;
      end
      if (edge_q == half - ONE) s0_q <= rx;
      if (edge_q == half)       s1_q <= rx;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    par_flag_d = par_flag_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    glitch_d   = 1'b0;
    cfg_load   = 1'b0;
    edge_d     = edge_q;
    bit_d      = bit_q;

    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d    = START;
          cfg_load   = 1'b1;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d  = IDLE;
          glitch_d = 1'b1;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_W-1:1]};
        if (wrap && bit_q == data_last) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (decide) par_flag_d = (^shift_q) ^ maj ^ par_typ_q;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Returning to IDLE at the final decision leaves half a bit of margin for a back-to-back start.
        if (decide) begin
          if (!maj) begin
            serr_d  = 1'b1;
            perr_d  = par_flag_q;
            state_d = BREAK;
          end else if (bit_q == stop_last) begin
            state_d = IDLE;
            if (par_flag_q) begin
              perr_d = 1'b1;
            end else begin
              dv_d    = 1'b1;
              pdata_d = shift_q;
            end
          end
        end
      end
      BREAK: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d == IDLE || state_d == BREAK) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (wrap) begin
      edge_d = '0;
      bit_d  = bit_q + 4'd1;
    end else begin
      edge_d = edge_q + ONE;
    end
  end

  assign bus.P_DATA      = pdata_q;
  assign bus.data_valid  = dv_q;
  assign bus.par_err     = perr_q;
  assign bus.stp_err     = serr_q;
  assign bus.strt_glitch = glitch_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a table of frames plus hand-written
// corner sequences, with expected pulses queued on a scoreboard.
module tb_uart_rx_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_ctrl_if #(.DATA_W(8), .PRESC_W(6)) bus8 ();
  uart_rx_ctrl_if #(.DATA_W(9), .PRESC_W(6)) bus9 ();

  uart_rx_ctrl #(.DATA_W(8), .PRESC_W(6)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
  uart_rx_ctrl #(.DATA_W(9), .PRESC_W(6)) dut9 (.CLK(CLK), .RST(RST), .bus(bus9));

  // mask bits: {strt_glitch, stp_err, par_err, data_valid}
  typedef struct {
    int         dut;
    logic [3:0] mask;
    logic [8:0] data;
    int         start;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stp2;
    logic [3:0] exp_mask;
  } vec_t;

  exp_t       sbq[$];
  int         dv_cyc[$];
  logic [8:0] last_good [2];
  int         n_vec = 0;
  int         n_fail = 0;
  vec_t       vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic observe(input int id, input logic [3:0] m, input logic [8:0] pd, input logic bsy);
    exp_t e;
    if (m == 4'b0000) return;
    if (sbq.size() == 0) begin
      check("unexpected_pulse", 32'(m), 32'd0);
      return;
    end
    e = sbq.pop_front();
    check("pulse_dut", 32'(id), 32'(e.dut));
    check("pulse_kind", 32'(m), 32'(e.mask));
    check("pulse_latency", 32'(cyc - e.start), 32'(e.lat));
    check("busy_at_pulse", 32'(bsy), 32'(e.mask[2]));
    if (e.mask[0]) begin
      check("p_data", 32'(pd), 32'(e.data));
      last_good[id] = e.data;
      dv_cyc.push_back(cyc);
    end else begin
      check("p_data_hold", 32'(pd), 32'(last_good[id]));
    end
  endtask

  always @(negedge CLK) begin
    observe(0, {bus8.strt_glitch, bus8.stp_err, bus8.par_err, bus8.data_valid},
            {1'b0, bus8.P_DATA}, bus8.busy);
    observe(1, {bus9.strt_glitch, bus9.stp_err, bus9.par_err, bus9.data_valid},
            bus9.P_DATA, bus9.busy);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_rx(input int id, input logic v);
    if (id == 0) bus8.RX_IN = v;
    else         bus9.RX_IN = v;
  endtask

  task automatic set_presc(input int id, input logic [5:0] p);
    if (id == 0) bus8.PRESCALE = p;
    else         bus9.PRESCALE = p;
  endtask

  task automatic set_cfg(input int id, input int p, input logic pe, input logic pt, input logic stp2);
    set_presc(id, 6'(p));
    if (id == 0) begin
      bus8.PAR_EN = pe; bus8.PAR_TYP = pt; bus8.STP2_EN = stp2;
    end else begin
      bus9.PAR_EN = pe; bus9.PAR_TYP = pt; bus9.STP2_EN = stp2;
    end
  endtask

  // Starts at 1 time unit after a rising edge; that cycle is cycle 0 of the frame.
  task automatic send_frame(input int id, input logic [8:0] data, input int width, input int p,
                            input logic pe, input logic pt, input logic pbit, input logic stp2,
                            input int alt_p, input int stop2_low, input logic [3:0] mask);
    exp_t e;
    int   n;
    set_cfg(id, p, pe, pt, stp2);
    set_rx(id, 1'b0);
    n       = 2 + width + int'(pe) + int'(stp2);
    e.dut   = id;
    e.mask  = mask;
    e.data  = data;
    e.start = cyc;
    e.lat   = 1 + p * (n - 1) + p / 2 + 2;
    sbq.push_back(e);
    tick(p);
    for (int i = 0; i < width; i++) begin
      set_rx(id, data[i]);
      if (alt_p != 0 && i == 2) set_presc(id, 6'(alt_p));
      if (alt_p != 0 && i == 6) set_presc(id, 6'(p));
      tick(p);
    end
    if (pe) begin
      set_rx(id, pbit);
      tick(p);
    end
    set_rx(id, 1'b1);
    tick(p);
    if (stp2) begin
      if (stop2_low > 0) begin
        set_rx(id, 1'b0);
        tick(stop2_low);
      end else begin
        tick(p);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && sbq.size() != 0; i++) tick(1);
    check("drain_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
    tick(3);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t g;
    vecs[0] = '{8'hA5, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{8'h0F, 6'd8,  1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[2] = '{8'h0F, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[3] = '{8'h0F, 6'd8,  1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[4] = '{8'h0F, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[5] = '{8'hC3, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[6] = '{8'h5A, 6'd62, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
    vecs[7] = '{8'h81, 6'd20, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};
    last_good[0] = '0;
    last_good[1] = '0;

    bus8.RX_IN = 1'b1; bus9.RX_IN = 1'b1;
    set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
    set_cfg(1, 8, 1'b0, 1'b0, 1'b0);
    #2 RST = 1'b0;
    tick(3);
    check("reset_busy8", 32'(bus8.busy), 32'd0);
    check("reset_pdata8", 32'(bus8.P_DATA), 32'd0);
    check("reset_pulses8", 32'({bus8.data_valid, bus8.par_err, bus8.stp_err, bus8.strt_glitch}), 32'd0);
    check("reset_busy9", 32'(bus9.busy), 32'd0);
    check("reset_pdata9", 32'(bus9.P_DATA), 32'd0);
    RST = 1'b1;
    tick(4);

    for (int i = 0; i < 8; i++) begin
      send_frame(0, {1'b0, vecs[i].data}, 8, int'(vecs[i].presc), vecs[i].pe, vecs[i].pt,
                 vecs[i].pbit, vecs[i].stp2, 0, 0, vecs[i].exp_mask);
      drain();
    end

    // Start-bit glitch: three low cycles are outvoted at the decision point.
    set_presc(0, 6'd16);
    set_rx(0, 1'b0);
    g.dut = 0; g.mask = 4'b1000; g.data = '0; g.start = cyc; g.lat = 11;
    sbq.push_back(g);
    tick(3);
    set_rx(0, 1'b1);
    drain();
    check("glitch_idle", 32'(bus8.busy), 32'd0);

    // Second stop bit held low: stop error, then BREAK until the line recovers.
    send_frame(0, 9'h096, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 40, 4'b0100);
    check("break_busy", 32'(bus8.busy), 32'd1);
    set_rx(0, 1'b1);
    tick(3);
    check("break_exit", 32'(bus8.busy), 32'd0);
    drain();
    send_frame(0, 9'h03C, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 4'b0001);
    drain();

    // Back-to-back frames with a mid-frame prescale change on the first one.
    dv_cyc.delete();
    send_frame(0, 9'h055, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 4'b0001);
    send_frame(0, 9'h0AA, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0001);
    drain();
    check("b2b_count", 32'(dv_cyc.size()), 32'd2);
    if (dv_cyc.size() == 2) check("b2b_gap", 32'(dv_cyc[1] - dv_cyc[0]), 32'd160);

    // Reset mid-DATA on the 9-bit receiver, then a clean frame.
    set_cfg(1, 8, 1'b0, 1'b0, 1'b0);
    set_rx(1, 1'b0);
    tick(8);
    set_rx(1, 1'b1);
    tick(8);
    set_rx(1, 1'b0);
    tick(4);
    check("abort_busy_before", 32'(bus9.busy), 32'd1);
    RST = 1'b0;
    #1;
    check("abort_busy_reset", 32'(bus9.busy), 32'd0);
    check("abort_pdata_reset", 32'(bus9.P_DATA), 32'd0);
    tick(3);
    set_rx(1, 1'b1);
    RST = 1'b1;
    last_good[0] = '0;
    last_good[1] = '0;
    tick(4);
    send_frame(1, 9'h081, 9, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0001);
    drain();
    check("final_pdata9", 32'(bus9.P_DATA), 32'h081);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
